// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
//   state_e : arbiter FSM encoding (IDLE, GNT_D, GNT_I, RESP_D, RESP_I)
//   gsel_e  : grant-select decision taken in IDLE
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_D  = 3'd1,
    GNT_I  = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    GSEL_NONE = 2'd0,
    GSEL_I    = 2'd1,
    GSEL_D    = 2'd2
  } gsel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
//   slave  : arbiter view (takes i_/d_ requests and m_ responses)
//   master : environment view (CHIP requesters plus the memory)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              m_req;
  logic              m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_stall, d_rdata, d_stall, m_req, m_wen, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_stall, d_rdata, d_stall, m_req, m_wen, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_age_ctr.sv
// Saturating count of fetch losses; sat tells the arbiter fetch must win next.
//   clk, rst_n : clock, async active-low reset
//   inc        : a data grant was taken while fetch was waiting
//   clr        : fetch was granted
//   sat        : counter has reached MAX_WAIT (registered)
module mem_arb_age_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Clear wins over increment; hold once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == CNT_W'(MAX_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (read-only)
// and the data path (read/write). Data has fixed priority; each access runs
// IDLE -> GNT_x -> RESP_x, so at least 3 cycles per access.
// Build option: MEM_ARB_AGE_EN adds an ageing counter that forces fetch to win
// after MAX_WAIT consecutive data grants taken while fetch was waiting.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus.i_*    : fetch request/address in, fetched word and stall out
//   bus.d_*    : data request/wen/address/wdata in, load word and stall out
//   bus.m_*    : memory req/wen/addr/wdata out, rdata/ack in
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef MEM_ARB_AGE_EN
  ,
  parameter int unsigned MAX_WAIT = 4
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  state_e            state_q, state_d;
  gsel_e             gsel_c;
  logic              m_req_q, m_req_d;
  logic              m_wen_q, m_wen_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_AGE_EN
  logic age_inc_c, age_clr_c, age_sat;

  // Ageing only counts decisions made in IDLE.
  assign age_inc_c = (state_q == IDLE) && (gsel_c == GSEL_D) && bus.i_req;
  assign age_clr_c = (state_q == IDLE) && (gsel_c == GSEL_I);

  mem_arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_age_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (age_inc_c),
    .clr   (age_clr_c),
    .sat   (age_sat)
  );
`endif

  // Grant decision: data first, unless fetch has aged out.
  always_comb begin
    gsel_c = GSEL_NONE;
    if (bus.d_req) begin
      gsel_c = GSEL_D;
    end else if (bus.i_req) begin
      gsel_c = GSEL_I;
    end
`ifdef MEM_ARB_AGE_EN
    if (age_sat && bus.d_req && bus.i_req) begin
      gsel_c = GSEL_I;
    end
`endif
  end

  // Next state and registered memory-side / read-data outputs.
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_wen_d   = m_wen_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        case (gsel_c)
          GSEL_D: begin
            state_d   = GNT_D;
            m_req_d   = 1'b1;
            m_wen_d   = bus.d_wen;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
          end
          GSEL_I: begin
            state_d   = GNT_I;
            m_req_d   = 1'b1;
            m_wen_d   = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end

      GNT_D: begin
        if (bus.m_ack) begin
          if (!m_wen_q) begin
            d_rdata_d = bus.m_rdata;
          end
          state_d   = RESP_D;
          m_req_d   = 1'b0;
          m_wen_d   = 1'b0;
          m_addr_d  = '0;
          m_wdata_d = '0;
        end
      end

      GNT_I: begin
        if (bus.m_ack) begin
          i_rdata_d = bus.m_rdata;
          state_d   = RESP_I;
          m_req_d   = 1'b0;
          m_wen_d   = 1'b0;
          m_addr_d  = '0;
          m_wdata_d = '0;
        end
      end

      // One dead cycle so a requester still releasing req is not re-granted.
      RESP_D, RESP_I: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        m_req_d   = 1'b0;
        m_wen_d   = 1'b0;
        m_addr_d  = '0;
        m_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_wen_q   <= m_wen_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_wen   = m_wen_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  // Stalls follow the request live and drop only in the requester's RESP cycle.
  assign bus.i_stall = bus.i_req && (state_q != RESP_I);
  assign bus.d_stall = bus.d_req && (state_q != RESP_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand sequences for
// asynchronous reset mid-grant and fetch ageing.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        e_mreq;
    logic        e_mwen;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_istall;
    logic        e_dstall;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t v(input string name,
                             input logic ir, input logic [31:0] ia,
                             input logic dr, input logic dw, input logic [31:0] da,
                             input logic [31:0] dwd,
                             input logic ack, input logic [31:0] mrd,
                             input logic emr, input logic emw, input logic [31:0] ema,
                             input logic [31:0] emwd,
                             input logic eis, input logic eds,
                             input logic [31:0] eird, input logic [31:0] edrd);
    vec_t r;
    r.name = name;   r.i_req = ir;    r.i_addr = ia;
    r.d_req = dr;    r.d_wen = dw;    r.d_addr = da;   r.d_wdata = dwd;
    r.m_ack = ack;   r.m_rdata = mrd;
    r.e_mreq = emr;  r.e_mwen = emw;  r.e_maddr = ema; r.e_mwdata = emwd;
    r.e_istall = eis; r.e_dstall = eds;
    r.e_irdata = eird; r.e_drdata = edrd;
    return r;
  endfunction

  task automatic check(input string name,
                       input logic emr, input logic emw,
                       input logic [31:0] ema, input logic [31:0] emwd,
                       input logic eis, input logic eds,
                       input logic [31:0] eird, input logic [31:0] edrd);
    n_vec++;
    if ({bus.m_req, bus.m_wen, bus.m_addr, bus.m_wdata,
         bus.i_stall, bus.d_stall, bus.i_rdata, bus.d_rdata} !==
        {emr, emw, ema, emwd, eis, eds, eird, edrd}) begin
      n_err++;
      $display("FAIL %s: got m_req=%b m_wen=%b m_addr=%h m_wdata=%h i_stall=%b d_stall=%b i_rdata=%h d_rdata=%h; want m_req=%b m_wen=%b m_addr=%h m_wdata=%h i_stall=%b d_stall=%b i_rdata=%h d_rdata=%h",
               name, bus.m_req, bus.m_wen, bus.m_addr, bus.m_wdata,
               bus.i_stall, bus.d_stall, bus.i_rdata, bus.d_rdata,
               emr, emw, ema, emwd, eis, eds, eird, edrd);
    end
  endtask

  task automatic drive_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wen   = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
  endtask

  initial begin
    logic [31:0] grants[$];
    logic [31:0] exp_grant;
    logic        prev_mreq;

    n_vec = 0;
    n_err = 0;
    drive_idle();
    rst_n = 1'b0;

    // Fetch, memory acks in the first m_req cycle.
    vecs.push_back(v("fetch_c0", 1, 32'h0001_0000, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v("fetch_c1", 1, 32'h0001_0000, 0, 0, 0, 0, 1, 32'h0000_0013,
                     1, 0, 32'h0001_0000, 0, 1, 0, 0, 0));
    vecs.push_back(v("fetch_c2", 1, 32'h0001_0000, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 32'h13, 0));
    vecs.push_back(v("fetch_c3", 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 32'h13, 0));
    // Store, ack on the fourth m_req cycle; d_rdata must not change.
    vecs.push_back(v("store_c0", 0, 0, 1, 1, 32'hbfff_ffe0, 32'hdead_beef, 0, 0,
                     0, 0, 0, 0, 0, 1, 32'h13, 0));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(v($sformatf("store_c%0d", k), 0, 0, 1, 1, 32'hbfff_ffe0, 32'hdead_beef, 0, 0,
                       1, 1, 32'hbfff_ffe0, 32'hdead_beef, 0, 1, 32'h13, 0));
    vecs.push_back(v("store_c4", 0, 0, 1, 1, 32'hbfff_ffe0, 32'hdead_beef, 1, 32'hffff_ffff,
                     1, 1, 32'hbfff_ffe0, 32'hdead_beef, 0, 1, 32'h13, 0));
    vecs.push_back(v("store_c5", 0, 0, 1, 1, 32'hbfff_ffe0, 32'hdead_beef, 0, 0,
                     0, 0, 0, 0, 0, 0, 32'h13, 0));
    vecs.push_back(v("store_c6", 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 32'h13, 0));
    // Simultaneous requests: data load first, then fetch.
    vecs.push_back(v("both_c0", 1, 32'h0001_0004, 1, 0, 32'h0001_0090, 0, 0, 0,
                     0, 0, 0, 0, 1, 1, 32'h13, 0));
    vecs.push_back(v("both_c1", 1, 32'h0001_0004, 1, 0, 32'h0001_0090, 0, 1, 32'h1234_5678,
                     1, 0, 32'h0001_0090, 0, 1, 1, 32'h13, 0));
    vecs.push_back(v("both_c2", 1, 32'h0001_0004, 1, 0, 32'h0001_0090, 0, 0, 0,
                     0, 0, 0, 0, 1, 0, 32'h13, 32'h1234_5678));
    vecs.push_back(v("both_c3", 1, 32'h0001_0004, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 1, 0, 32'h13, 32'h1234_5678));
    vecs.push_back(v("both_c4", 1, 32'h0001_0004, 0, 0, 0, 0, 1, 32'hcafe_f00d,
                     1, 0, 32'h0001_0004, 0, 1, 0, 32'h13, 32'h1234_5678));
    vecs.push_back(v("both_c5", 1, 32'h0001_0004, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 32'hcafe_f00d, 32'h1234_5678));
    vecs.push_back(v("both_c6", 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 32'hcafe_f00d, 32'h1234_5678));

    // Reset state, then 10 idle cycles with no memory request.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1 check($sformatf("idle_%0d", k), 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Cycle-by-cycle vector table.
    foreach (vecs[k]) begin
      @(negedge clk);
      bus.i_req   = vecs[k].i_req;
      bus.i_addr  = vecs[k].i_addr;
      bus.d_req   = vecs[k].d_req;
      bus.d_wen   = vecs[k].d_wen;
      bus.d_addr  = vecs[k].d_addr;
      bus.d_wdata = vecs[k].d_wdata;
      bus.m_ack   = vecs[k].m_ack;
      bus.m_rdata = vecs[k].m_rdata;
      #1 check(vecs[k].name, vecs[k].e_mreq, vecs[k].e_mwen, vecs[k].e_maddr,
               vecs[k].e_mwdata, vecs[k].e_istall, vecs[k].e_dstall,
               vecs[k].e_irdata, vecs[k].e_drdata);
    end

    // Async reset during GNT_D with ack withheld, then re-grant of held d_req.
    @(negedge clk);
    drive_idle();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0044;
    #1 check("rst_idle", 0, 0, 0, 0, 0, 1, 32'hcafe_f00d, 32'h1234_5678);
    @(negedge clk);
    #1 check("rst_gnt", 1, 0, 32'h44, 0, 0, 1, 32'hcafe_f00d, 32'h1234_5678);
    @(negedge clk);
    #1 check("rst_gnt_hold", 1, 0, 32'h44, 0, 0, 1, 32'hcafe_f00d, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release", 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1 check("rst_regrant", 1, 0, 32'h44, 0, 0, 1, 0, 0);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h0000_0055;
    @(negedge clk);
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    #1 check("rst_resp", 0, 0, 0, 0, 0, 0, 0, 32'h55);
    @(negedge clk);
    drive_idle();

    // Ageing: both requests held, memory acks every request immediately.
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0200;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0100;
    prev_mreq  = 1'b0;
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      @(negedge clk);
      #1;
      bus.m_ack = bus.m_req;
      bus.m_rdata = 32'h0000_0a00 + 32'(c);
      if (bus.m_req && !prev_mreq) grants.push_back(bus.m_addr);
      prev_mreq = bus.m_req;
    end
    @(negedge clk);
    drive_idle();
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_AGE_EN
      exp_grant = (g == 4) ? 32'h0000_0100 : 32'h0000_0200;
`else
      exp_grant = 32'h0000_0200;
`endif
      n_vec++;
      if (g >= grants.size()) begin
        n_err++;
        $display("FAIL age_grant_%0d: no grant seen within cycle budget, want addr %h", g, exp_grant);
      end else if (grants[g] !== exp_grant) begin
        n_err++;
        $display("FAIL age_grant_%0d: got addr %h, want %h", g, grants[g], exp_grant);
      end
    end
    repeat (4) @(negedge clk);
    #1 check("final_idle", 0, 0, 0, 0, 0, 0, bus.i_rdata, bus.d_rdata);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
